// File: rtl/regs_pkg.sv
// Shared register-file defines plus the regs package (types, sizes, debug FSM states).
// Optional feature macro used by regs: REGS_BYPASS_EN (write-to-read forwarding).
`ifndef REGS_DEFINES_V
`define REGS_DEFINES_V
`define RADDR_WIDTH   5
`define RDATA_WIDTH   32
`define REG_NUM       32
`define ZERO_REG      {`RADDR_WIDTH{1'b0}}
`define ZERO          {`RDATA_WIDTH{1'b0}}
`define READ_ENABLE   1'b1
`define READ_DISABLE  1'b0
`define WRITE_ENABLE  1'b1
`define WRITE_DISABLE 1'b0
`endif

package regs_pkg;

    localparam int unsigned RADDR_W = `RADDR_WIDTH;
    localparam int unsigned RDATA_W = `RDATA_WIDTH;
    localparam int unsigned REG_NUM = `REG_NUM;

    typedef logic [RADDR_W-1:0] raddr_t;
    typedef logic [RDATA_W-1:0] rdata_t;

    typedef enum logic [1:0] {
        DBG_IDLE    = 2'd0,
        DBG_ACCESS  = 2'd1,
        DBG_ACK     = 2'd2,
        DBG_RELEASE = 2'd3
    } dbg_state_e;

    function automatic logic is_zero_idx(input raddr_t idx);
        return idx == `ZERO_REG;
    endfunction

endpackage

// File: rtl/regs_dbg_ctrl.sv
// Debug access handshake: IDLE -> ACCESS -> ACK -> RELEASE, with core writes
// taking priority over a pending debug write.
module regs_dbg_ctrl
    import regs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic dbg_req_i,
    input  logic dbg_we_i,
    input  logic we_i,
    output logic dbg_ack_o,
    output logic dbg_wr_o,
    output logic dbg_rd_o
);

    dbg_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DBG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DBG_IDLE:    if (dbg_req_i) state_d = DBG_ACCESS;
            // A debug write waits here while the core is writing back.
            DBG_ACCESS:  if (!(dbg_we_i && we_i)) state_d = DBG_ACK;
            DBG_ACK:     state_d = DBG_RELEASE;
            DBG_RELEASE: if (!dbg_req_i) state_d = DBG_IDLE;
            default:     state_d = DBG_IDLE;
        endcase
    end

    always_comb begin
        dbg_ack_o = 1'b0;
        dbg_wr_o  = 1'b0;
        dbg_rd_o  = 1'b0;
        case (state_q)
            DBG_ACCESS: begin
                dbg_wr_o = dbg_we_i && !we_i;
                dbg_rd_o = !dbg_we_i;
            end
            DBG_ACK:    dbg_ack_o = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: rtl/regs.sv
// Register file with two combinational read ports, one core write port and a
// debug access port. Define REGS_BYPASS_EN to forward same-cycle write data to reads.
module regs
    import regs_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [RADDR_W-1:0] waddr_i,
    input  logic [RDATA_W-1:0] wdata_i,
    input  logic [RADDR_W-1:0] raddr1_i,
    input  logic               re1_i,
    input  logic [RADDR_W-1:0] raddr2_i,
    input  logic               re2_i,
    output logic [RDATA_W-1:0] rdata1_o,
    output logic [RDATA_W-1:0] rdata2_o,
    input  logic               dbg_req_i,
    input  logic               dbg_we_i,
    input  logic [RADDR_W-1:0] dbg_addr_i,
    input  logic [RDATA_W-1:0] dbg_wdata_i,
    output logic               dbg_ack_o,
    output logic [RDATA_W-1:0] dbg_rdata_o
);

    rdata_t mem_q [REG_NUM];
    rdata_t mem_d [REG_NUM];
    rdata_t dbg_rdata_q, dbg_rdata_d;
    logic   dbg_wr, dbg_rd;

    regs_dbg_ctrl u_dbg_ctrl (
        .clk       (clk),
        .rst       (rst),
        .dbg_req_i (dbg_req_i),
        .dbg_we_i  (dbg_we_i),
        .we_i      (we_i),
        .dbg_ack_o (dbg_ack_o),
        .dbg_wr_o  (dbg_wr),
        .dbg_rd_o  (dbg_rd)
    );

    always_comb begin
        mem_d       = mem_q;
        dbg_rdata_d = dbg_rdata_q;
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) mem_d[i] = `ZERO;
            dbg_rdata_d = `ZERO;
        end else begin
            if (we_i == `WRITE_ENABLE && !is_zero_idx(waddr_i)) begin
                mem_d[waddr_i] = wdata_i;
            end else if (dbg_wr && !is_zero_idx(dbg_addr_i)) begin
                mem_d[dbg_addr_i] = dbg_wdata_i;
            end
            // Captured from the stored value, so a same-cycle core write is not seen.
            if (dbg_rd) begin
                dbg_rdata_d = is_zero_idx(dbg_addr_i) ? `ZERO : mem_q[dbg_addr_i];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q       <= mem_d;
        dbg_rdata_q <= dbg_rdata_d;
    end

    always_comb begin
        rdata1_o = `ZERO;
        if (re1_i == `READ_ENABLE && !is_zero_idx(raddr1_i)) begin
            rdata1_o = mem_q[raddr1_i];
`ifdef REGS_BYPASS_EN
            if (we_i == `WRITE_ENABLE && waddr_i == raddr1_i) rdata1_o = wdata_i;
`endif
        end
    end

    always_comb begin
        rdata2_o = `ZERO;
        if (re2_i == `READ_ENABLE && !is_zero_idx(raddr2_i)) begin
            rdata2_o = mem_q[raddr2_i];
`ifdef REGS_BYPASS_EN
            if (we_i == `WRITE_ENABLE && waddr_i == raddr2_i) rdata2_o = wdata_i;
`endif
        end
    end

    assign dbg_rdata_o = dbg_rdata_q;

endmodule
